load_ext_unit: RTL and testbench

- Load-data extension stage for the P6 pipelined MIPS CPU; sits between the data memory read port and the writeback mux.
- Selects the byte, halfword or word from a little-endian 32-bit memory word and sign- or zero-extends it to 32 bits.
- Also provides the immediate-style "upper half" extension (value placed in bits 31:16).
- Result is available combinationally and as a registered, valid-qualified copy.

---
 rtl/load_ext_unit_if.sv | 33 +++
 rtl/load_ext_unit.sv | 90 +++++++++
 tb/tb_load_ext_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/load_ext_unit_if.sv
// Load-extension bus: memory-side request fields plus extended results.
// Misalignment flags exist only when LOAD_EXT_MISALIGN_CHECK_EN is defined.
interface load_ext_unit_if;
    logic        in_valid;
    logic [1:0]  mem_dst;
    logic [1:0]  ext_op;
    logic        isu;
    logic [1:0]  byte_off;
    logic [31:0] rdata_in;
    logic [31:0] ext_comb;
    logic [31:0] ext_q;
    logic        valid_q;
`ifdef LOAD_EXT_MISALIGN_CHECK_EN
    logic        misalign;
    logic        misalign_q;
`endif

    modport master (
        output in_valid, mem_dst, ext_op, isu, byte_off, rdata_in,
        input  ext_comb, ext_q, valid_q
`ifdef LOAD_EXT_MISALIGN_CHECK_EN
        , input misalign, misalign_q
`endif
    );

    modport slave (
        input  in_valid, mem_dst, ext_op, isu, byte_off, rdata_in,
        output ext_comb, ext_q, valid_q
`ifdef LOAD_EXT_MISALIGN_CHECK_EN
        , output misalign, misalign_q
`endif
    );
endinterface

// File: rtl/load_ext_unit.sv
// Load-data extension stage: byte/halfword/word select with sign/zero/upper extension.
// Optional misalignment flag built only when LOAD_EXT_MISALIGN_CHECK_EN is defined.
module load_ext_unit #(
    parameter int unsigned PIPE = 1
) (
    input  logic           clk,
    input  logic           reset,
    load_ext_unit_if.slave bus
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext_comb;

    always_comb begin
        // NOTE: every variable gets a default first, so no path through the case can infer a latch.
        byte_sel = bus.rdata_in[{bus.byte_off, 3'b000} +: 8];
        half_sel = bus.rdata_in[{bus.byte_off[1], 4'b0000} +: 16];
        ext_comb = bus.isu ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        case (bus.mem_dst)
            2'd1: begin
                case (bus.ext_op)
                    2'd0:    ext_comb = {{16{half_sel[15]}}, half_sel};
                    2'd2:    ext_comb = {half_sel, 16'h0};
                    default: ext_comb = {16'h0, half_sel};
                endcase
            end
            2'd3:    ext_comb = bus.rdata_in;
            default: ; // byte and reserved encoding keep the byte result
        endcase
    end

    assign bus.ext_comb = ext_comb;

`ifdef LOAD_EXT_MISALIGN_CHECK_EN
    logic misalign;

    assign misalign = bus.in_valid &&
                      (((bus.mem_dst == 2'd1) && bus.byte_off[0]) ||
                       ((bus.mem_dst == 2'd3) && (bus.byte_off != 2'd0)));
    assign bus.misalign = misalign;
`endif

    generate
        if (PIPE != 0) begin : g_pipe
            logic [31:0] ext_d, ext_q;
            logic        valid_d, valid_q;

            always_comb begin
                ext_d   = bus.in_valid ? ext_comb : ext_q;
                valid_d = bus.in_valid;
            end

            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    ext_q   <= '0;
                    valid_q <= 1'b0;
                end else begin
                    ext_q   <= ext_d;
                    valid_q <= valid_d;
                end
            end

            assign bus.ext_q   = ext_q;
            assign bus.valid_q = valid_q;

`ifdef LOAD_EXT_MISALIGN_CHECK_EN
            logic misalign_d, misalign_q;

            always_comb misalign_d = misalign;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) misalign_q <= 1'b0;
                else        misalign_q <= misalign_d;
            end

            assign bus.misalign_q = misalign_q;
`endif
        end else begin : g_bypass
            // Unregistered build: the "registered" outputs simply mirror the live path.
            assign bus.ext_q   = ext_comb;
            assign bus.valid_q = bus.in_valid;
`ifdef LOAD_EXT_MISALIGN_CHECK_EN
            assign bus.misalign_q = misalign;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_load_ext_unit.sv
// Self-checking bench for load_ext_unit (PIPE=1): directed table, corner sequences,
// and randomized traffic against an arithmetic reference model.
module tb_load_ext_unit;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    load_ext_unit_if bus ();

    load_ext_unit #(.PIPE(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mem_dst;
        logic [1:0]  ext_op;
        logic        isu;
        logic [1:0]  off;
        logic [31:0] rdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic valid, input logic [1:0] md, input logic [1:0] eo,
                         input logic isu, input logic [1:0] off, input logic [31:0] w);
        bus.in_valid = valid;
        bus.mem_dst  = md;
        bus.ext_op   = eo;
        bus.isu      = isu;
        bus.byte_off = off;
        bus.rdata_in = w;
    endtask

    // Reference: extract by shifting and masking, extend by adding the sign pattern.
    function automatic logic [31:0] model(input logic [1:0] md, input logic [1:0] eo,
                                          input logic isu, input logic [1:0] off,
                                          input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> ((off >= 2) ? 16 : 0)) & 32'hFFFF;
        if (md == 2'd3) return w;
        if (md == 2'd1) begin
            if (eo == 2'd2) return h * 65536;
            if (eo == 2'd0 && h >= 32768) return h + 32'hFFFF0000;
            return h;
        end
        if (!isu && b >= 128) return b + 32'hFFFFFF00;
        return b;
    endfunction

    logic [31:0] model_q;
    logic        model_v;

    initial begin
        checks   = 0;
        failures = 0;
        vecs[0]  = '{2'd0, 2'd0, 1'b0, 2'd0, 32'h80FF7F01, 32'h00000001};
        vecs[1]  = '{2'd0, 2'd0, 1'b0, 2'd1, 32'h80FF7F01, 32'h0000007F};
        vecs[2]  = '{2'd0, 2'd0, 1'b0, 2'd2, 32'h80FF7F01, 32'hFFFFFFFF};
        vecs[3]  = '{2'd0, 2'd0, 1'b0, 2'd3, 32'h80FF7F01, 32'hFFFFFF80};
        vecs[4]  = '{2'd0, 2'd0, 1'b1, 2'd0, 32'h80FF7F01, 32'h00000001};
        vecs[5]  = '{2'd0, 2'd0, 1'b1, 2'd1, 32'h80FF7F01, 32'h0000007F};
        vecs[6]  = '{2'd0, 2'd0, 1'b1, 2'd2, 32'h80FF7F01, 32'h000000FF};
        vecs[7]  = '{2'd0, 2'd0, 1'b1, 2'd3, 32'h80FF7F01, 32'h00000080};
        vecs[8]  = '{2'd1, 2'd0, 1'b0, 2'd0, 32'h8001ABCD, 32'hFFFFABCD};
        vecs[9]  = '{2'd1, 2'd1, 1'b0, 2'd0, 32'h8001ABCD, 32'h0000ABCD};
        vecs[10] = '{2'd1, 2'd2, 1'b0, 2'd0, 32'h8001ABCD, 32'hABCD0000};
        vecs[11] = '{2'd1, 2'd3, 1'b0, 2'd0, 32'h8001ABCD, 32'h0000ABCD};
        vecs[12] = '{2'd1, 2'd0, 1'b0, 2'd2, 32'h8001ABCD, 32'hFFFF8001};
        vecs[13] = '{2'd1, 2'd0, 1'b1, 2'd1, 32'h8001ABCD, 32'hFFFFABCD};
        vecs[14] = '{2'd1, 2'd1, 1'b0, 2'd3, 32'h8001ABCD, 32'h00008001};
        vecs[15] = '{2'd2, 2'd2, 1'b0, 2'd3, 32'h80FF7F01, 32'hFFFFFF80};
        vecs[16] = '{2'd2, 2'd0, 1'b1, 2'd2, 32'h80FF7F01, 32'h000000FF};
        vecs[17] = '{2'd3, 2'd0, 1'b0, 2'd0, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[18] = '{2'd3, 2'd2, 1'b1, 2'd1, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[19] = '{2'd3, 2'd1, 1'b0, 2'd2, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[20] = '{2'd3, 2'd3, 1'b1, 2'd3, 32'hDEADBEEF, 32'hDEADBEEF};

        // Reset state, asserted asynchronously before any clock edge.
        drive(1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 32'h0);
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("reset_ext_q", bus.ext_q, 32'h0);
        check("reset_valid_q", {31'h0, bus.valid_q}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Directed table: combinational result, then the registered copy.
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            drive(1'b1, vecs[i].mem_dst, vecs[i].ext_op, vecs[i].isu, vecs[i].off, vecs[i].rdata);
            #1 check($sformatf("comb_vec%0d", i), bus.ext_comb, vecs[i].exp);
            @(posedge clk);
            #1;
            check($sformatf("ext_q_vec%0d", i), bus.ext_q, vecs[i].exp);
            check($sformatf("valid_q_vec%0d", i), {31'h0, bus.valid_q}, 32'h1);
        end

        // Hold: invalid samples with changing data must not disturb ext_q.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b0, 2'd3, 2'd0, 1'b0, 2'd0, $urandom);
            @(posedge clk);
            #1;
            check("hold_ext_q", bus.ext_q, 32'hDEADBEEF);
            check("hold_valid_q", {31'h0, bus.valid_q}, 32'h0);
        end

        // Mid-cycle reset discards the in-flight sample, then capture resumes.
        @(negedge clk);
        drive(1'b1, 2'd3, 2'd0, 1'b0, 2'd0, 32'h12345678);
        @(posedge clk);
        #1 check("load_12345678", bus.ext_q, 32'h12345678);
        @(negedge clk);
        drive(1'b1, 2'd3, 2'd0, 1'b0, 2'd0, 32'hAAAA5555);
        #2 reset = 1'b0;
        #1;
        check("async_rst_ext_q", bus.ext_q, 32'h0);
        check("async_rst_valid_q", {31'h0, bus.valid_q}, 32'h0);
        @(posedge clk);
        #1 check("held_rst_ext_q", bus.ext_q, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 2'd3, 2'd0, 1'b0, 2'd0, 32'h0BADF00D);
        @(posedge clk);
        #1;
        check("post_rst_ext_q", bus.ext_q, 32'h0BADF00D);
        check("post_rst_valid_q", {31'h0, bus.valid_q}, 32'h1);

`ifdef LOAD_EXT_MISALIGN_CHECK_EN
        @(negedge clk);
        drive(1'b1, 2'd1, 2'd0, 1'b0, 2'd1, 32'h0);
        #1 check("misalign_half_off1", {31'h0, bus.misalign}, 32'h1);
        @(posedge clk);
        #1 check("misalign_q_half_off1", {31'h0, bus.misalign_q}, 32'h1);
        @(negedge clk);
        drive(1'b1, 2'd3, 2'd0, 1'b0, 2'd2, 32'h0);
        #1 check("misalign_word_off2", {31'h0, bus.misalign}, 32'h1);
        drive(1'b1, 2'd0, 2'd0, 1'b0, 2'd3, 32'h0);
        #1 check("misalign_byte_off3", {31'h0, bus.misalign}, 32'h0);
        drive(1'b0, 2'd3, 2'd0, 1'b0, 2'd1, 32'h0);
        #1 check("misalign_invalid", {31'h0, bus.misalign}, 32'h0);
        @(posedge clk);
        #1 check("misalign_q_invalid", {31'h0, bus.misalign_q}, 32'h0);
`endif

        // Randomized traffic against the reference model and a scoreboard register.
        model_q = bus.ext_q;
        model_v = bus.valid_q;
        for (int i = 0; i < 300; i++) begin
            logic        v, isu;
            logic [1:0]  md, eo, off;
            logic [31:0] w;
            v   = 1'($urandom_range(0, 1));
            md  = 2'($urandom_range(0, 3));
            eo  = 2'($urandom_range(0, 3));
            isu = 1'($urandom_range(0, 1));
            off = 2'($urandom_range(0, 3));
            w   = $urandom;
            @(negedge clk);
            drive(v, md, eo, isu, off, w);
            #1 check("rand_comb", bus.ext_comb, model(md, eo, isu, off, w));
            if (v) model_q = model(md, eo, isu, off, w);
            model_v = v;
            @(posedge clk);
            #1;
            check("rand_ext_q", bus.ext_q, model_q);
            check("rand_valid_q", {31'h0, bus.valid_q}, {31'h0, model_v});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
